// File: rtl/event_hdr_reader_pkg.sv
// Shared constants and types for the event-header reader: header layout and reader FSM states.
package event_hdr_reader_pkg;

  localparam int unsigned HdrNumDwords  = 6;
  localparam logic [31:0] HdrIdentifier = 32'h5244_4530;  // "RDE0"

  typedef enum logic [2:0] {
    DwId,
    DwSec,
    DwEvcount,
    DwSysclk,
    DwInfo,
    DwStatus
  } dword_idx_e;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/hdr_mismatch_watchdog.sv
// Flags header FIFOs that stay partially occupied too long while the reader is idle.
// Sticky error; a set and a clear in the same cycle resolve to set.
module hdr_mismatch_watchdog #(
  parameter int unsigned NUM_FIFOS = 5,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 idle_i,
  input  logic [NUM_FIFOS-1:0] empty_i,
  input  logic                 err_clr_i,
  output logic                 hdr_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            partial;
  logic            set;

  always_comb begin
    partial = idle_i && (|empty_i) && !(&empty_i);
    // Fire only on the crossing so a clear while still misaligned stays cleared.
    set     = partial && (cnt_q == CntW'(TIMEOUT - 1));
    cnt_d   = '0;
    if (partial) begin
      cnt_d = (cnt_q == CntW'(TIMEOUT)) ? cnt_q : cnt_q + CntW'(1);
    end
    err_d = set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign hdr_err_o = err_q;

endmodule

// File: rtl/event_hdr_reader.sv
// Drains one entry from each per-dword header FIFO as a NUM_DWORDS-dword valid/ready stream.
// Optional misalignment watchdog enabled by defining EVENT_HDR_READER_CHECK_EN.
module event_hdr_reader
  import event_hdr_reader_pkg::*;
#(
  parameter int unsigned NUM_DWORDS       = HdrNumDwords,
  parameter logic [31:0] IDENTIFIER       = HdrIdentifier,
  parameter int unsigned MISMATCH_TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       enable_i,
  input  logic [NUM_DWORDS-2:0]      hdr_empty_i,
  input  logic [32*(NUM_DWORDS-1)-1:0] hdr_dout_i,
  output logic [NUM_DWORDS-2:0]      hdr_rden_o,
  output logic [31:0]                m_tdata_o,
  output logic                       m_tvalid_o,
  input  logic                       m_tready_i,
  output logic                       m_tlast_o,
  output logic                       event_done_o,
  output logic [31:0]                events_read_o,
  output logic                       hdr_err_o,
  input  logic                       err_clr_i
);

  localparam int unsigned    IdxW    = $clog2(NUM_DWORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DWORDS - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            tvalid_q;
  logic            tlast_q;
  logic            done_q;
  logic [31:0]     events_q;
  logic            accept;

  assign accept = tvalid_q & m_tready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      idx_q    <= IdxW'(DwId);
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      events_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable_i && !(|hdr_empty_i)) begin
            state_q  <= StSend;
            idx_q    <= IdxW'(DwId);
            tvalid_q <= 1'b1;
            tlast_q  <= (LastIdx == IdxW'(DwId));
          end
        end
        StSend: begin
          if (m_tready_i) begin
            if (idx_q == LastIdx) begin
              state_q  <= StDone;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
              events_q <= events_q + 32'd1;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              tlast_q <= ((idx_q + IdxW'(1)) == LastIdx);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          idx_q   <= IdxW'(DwId);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data follows the FWFT outputs directly; pop in the cycle the dword is taken.
  always_comb begin
    m_tdata_o  = IDENTIFIER;
    hdr_rden_o = '0;
    for (int k = 1; k < NUM_DWORDS; k++) begin
      if (idx_q == IdxW'(k)) begin
        m_tdata_o       = hdr_dout_i[32*(k-1) +: 32];
        hdr_rden_o[k-1] = accept;
      end
    end
  end

  assign m_tvalid_o    = tvalid_q;
  assign m_tlast_o     = tlast_q;
  assign event_done_o  = done_q;
  assign events_read_o = events_q;

`ifdef EVENT_HDR_READER_CHECK_EN
  hdr_mismatch_watchdog #(
    .NUM_FIFOS(NUM_DWORDS - 1),
    .TIMEOUT  (MISMATCH_TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .idle_i   (state_q == StIdle),
    .empty_i  (hdr_empty_i),
    .err_clr_i(err_clr_i),
    .hdr_err_o(hdr_err_o)
  );
`else
  localparam int unsigned UnusedTimeout = MISMATCH_TIMEOUT;
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign hdr_err_o      = 1'b0;
`endif

endmodule
